// File: rtl/traffic_pkg.sv
// traffic_pkg: light codes and sensor-debounce encoding shared by the traffic
// controller and the queue monitors that feed it.
package traffic_pkg;

    localparam logic [1:0] LIGHT_DARK   = 2'b00;
    localparam logic [1:0] LIGHT_RED    = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b10;
    localparam logic [1:0] LIGHT_GREEN  = 2'b11;

    localparam int DEBOUNCE_DEFAULT = 3;

    typedef enum logic [1:0] {
        DEB_LOW,
        DEB_RISE_CHK,
        DEB_HIGH,
        DEB_FALL_CHK
    } deb_state_e;

endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: two-flop synchronizer and level debounce for the road loop;
// emits a registered one-cycle arrive pulse per accepted rising level.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor,
    output logic arrive
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [1:0]    sync_q, sync_d;
    deb_state_e    state_q, state_d;
    logic [CW-1:0] deb_cnt_q, deb_cnt_d;
    logic          arrive_q, arrive_d;
    logic          sensor_s;

    assign sensor_s = sync_q[1];
    assign arrive   = arrive_q;

    always_comb begin
        sync_d    = {sync_q[0], sensor};
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        arrive_d  = 1'b0;
        unique case (state_q)
            DEB_LOW: begin
                if (sensor_s) begin
                    state_d   = DEB_RISE_CHK;
                    deb_cnt_d = CW'(1);
                end
            end
            DEB_RISE_CHK: begin
                if (!sensor_s) begin
                    state_d = DEB_LOW;
                end else if (deb_cnt_q + CW'(1) == CW'(DEBOUNCE)) begin
                    state_d  = DEB_HIGH;
                    arrive_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            DEB_HIGH: begin
                if (!sensor_s) begin
                    state_d   = DEB_FALL_CHK;
                    deb_cnt_d = CW'(1);
                end
            end
            DEB_FALL_CHK: begin
                if (sensor_s) begin
                    state_d = DEB_HIGH;
                end else if (deb_cnt_q + CW'(1) == CW'(DEBOUNCE)) begin
                    state_d = DEB_LOW;
                end else begin
                    deb_cnt_d = deb_cnt_q + CW'(1);
                end
            end
            default: state_d = DEB_LOW;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q    <= '0;
            state_q   <= DEB_LOW;
            deb_cnt_q <= '0;
            arrive_q  <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            arrive_q  <= arrive_d;
        end
    end

endmodule

// File: rtl/sr_queue_monitor.sv
// sr_queue_monitor: counts cars waiting at the secondary-road light for the
// controller's MR_cars input and flags illegal light combinations.
module sr_queue_monitor
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE    = DEBOUNCE_DEFAULT,
    parameter int DEPART_TIME = 2,
    parameter int CNT_MAX     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car_sensor,
    input  logic [1:0] MR_ctl,
    input  logic [1:0] SR_ctl,
    output logic [7:0] MR_cars,
    output logic       cars_sat,
    output logic [1:0] fault
);

    localparam int DW = $clog2(DEPART_TIME + 1);

    logic          arrive, depart, sr_green;
    logic [DW-1:0] dep_cnt_q, dep_cnt_d;
    logic [7:0]    mr_cars_q, mr_cars_d;
    logic          cars_sat_q, cars_sat_d;
    logic [1:0]    fault_q, fault_d;
    logic [1:0]    prev_sr_q, prev_sr_d;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .sensor (car_sensor),
        .arrive (arrive)
    );

    assign MR_cars  = mr_cars_q;
    assign cars_sat = cars_sat_q;
    assign fault    = fault_q;

    always_comb begin
        sr_green   = SR_ctl == LIGHT_GREEN;
        depart     = sr_green && dep_cnt_q == DW'(DEPART_TIME - 1);
        dep_cnt_d  = (!sr_green || depart) ? '0 : dep_cnt_q + DW'(1);
        mr_cars_d  = mr_cars_q;
        cars_sat_d = cars_sat_q;
        // A coincident arrival and departure cancel, even at the count limits.
        if (arrive && !depart) begin
            if (mr_cars_q == 8'(CNT_MAX)) cars_sat_d = 1'b1;
            else                          mr_cars_d  = mr_cars_q + 8'd1;
        end else if (depart && !arrive && mr_cars_q != 8'd0) begin
            mr_cars_d = mr_cars_q - 8'd1;
        end
        fault_d   = fault_q | {sr_green && prev_sr_q != LIGHT_YELLOW && prev_sr_q != LIGHT_GREEN,
                               sr_green && MR_ctl == LIGHT_GREEN};
        prev_sr_d = SR_ctl;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dep_cnt_q  <= '0;
            mr_cars_q  <= '0;
            cars_sat_q <= 1'b0;
            fault_q    <= '0;
            prev_sr_q  <= LIGHT_DARK;
        end else begin
            dep_cnt_q  <= dep_cnt_d;
            mr_cars_q  <= mr_cars_d;
            cars_sat_q <= cars_sat_d;
            fault_q    <= fault_d;
            prev_sr_q  <= prev_sr_d;
        end
    end

endmodule

// File: tb/tb_sr_queue_monitor.sv
// tb_sr_queue_monitor: directed and random traffic against a sample-level
// reference model; expectations are queued per edge and checked by a monitor.
module tb_sr_queue_monitor;
    import traffic_pkg::*;

    localparam int DEB  = 3;
    localparam int DT   = 2;
    localparam int CMAX = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       car_sensor = 1'b0;
    logic [1:0] MR_ctl = LIGHT_RED;
    logic [1:0] SR_ctl = LIGHT_RED;
    logic [7:0] MR_cars;
    logic       cars_sat;
    logic [1:0] fault;

    typedef struct packed {
        logic [7:0] cars;
        logic       sat;
        logic [1:0] flt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int         m_cars, m_run, m_grun, m_edge;
    bit         m_sat, m_lvl;
    bit   [1:0] m_fault;
    logic [1:0] m_prev;
    int         m_pend[$];

    sr_queue_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .car_sensor (car_sensor),
        .MR_ctl     (MR_ctl),
        .SR_ctl     (SR_ctl),
        .MR_cars    (MR_cars),
        .cars_sat   (cars_sat),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cars = 0; m_run = 0; m_grun = 0; m_edge = 0;
        m_sat = 0; m_lvl = 0; m_fault = 0; m_prev = LIGHT_DARK;
        m_pend.delete();
    endfunction

    // Drive one cycle at a falling edge and queue the state expected after the next rising edge.
    task automatic cyc(input logic s, input logic [1:0] mr, input logic [1:0] sr);
        bit arr, dep;
        car_sensor = s; MR_ctl = mr; SR_ctl = sr;
        m_edge++;
        if (s != m_lvl) begin
            m_run++;
            if (m_run == DEB) begin
                m_lvl = s;
                m_run = 0;
                if (s) m_pend.push_back(m_edge + 3);
            end
        end else begin
            m_run = 0;
        end
        m_grun = (sr == LIGHT_GREEN) ? m_grun + 1 : 0;
        dep = m_grun != 0 && m_grun % DT == 0;
        arr = m_pend.size() != 0 && m_pend[0] == m_edge;
        if (arr) void'(m_pend.pop_front());
        if (arr && !dep) begin
            if (m_cars == CMAX) m_sat = 1;
            else m_cars++;
        end else if (dep && !arr && m_cars > 0) begin
            m_cars--;
        end
        if (mr == LIGHT_GREEN && sr == LIGHT_GREEN) m_fault[0] = 1;
        if (sr == LIGHT_GREEN && m_prev != LIGHT_YELLOW && m_prev != LIGHT_GREEN) m_fault[1] = 1;
        m_prev = sr;
        exp_q.push_back('{cars: 8'(m_cars), sat: m_sat, flt: m_fault});
        @(negedge clk);
    endtask

    task automatic hold(input logic s, input logic [1:0] mr, input logic [1:0] sr, input int n);
        for (int i = 0; i < n; i++) cyc(s, mr, sr);
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, LIGHT_RED, LIGHT_RED, 4);
            hold(1'b0, LIGHT_RED, LIGHT_RED, 4);
        end
        hold(1'b0, LIGHT_RED, LIGHT_RED, 4);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({MR_cars, cars_sat, fault} !== 11'd0) begin
            errors++;
            $display("FAIL reset_clear: got cars=%0d sat=%0b fault=%b, want all zero", MR_cars, cars_sat, fault);
        end
        car_sensor = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({MR_cars, cars_sat, fault} !== e) begin
                    errors++;
                    $display("FAIL edge_state @%0t: got cars=%0d sat=%0b fault=%b, want cars=%0d sat=%0b fault=%b",
                             $time, MR_cars, cars_sat, fault, e.cars, e.sat, e.flt);
                end
            end
        end
    end

    initial begin : stimulus
        int slen, llen;
        logic s;
        logic [1:0] mr, sr;
        model_reset();
        @(negedge clk);
        do_reset();
        hold(1'b1, LIGHT_RED, LIGHT_RED, 10);
        hold(1'b0, LIGHT_RED, LIGHT_RED, 10);
        hold(1'b1, LIGHT_RED, LIGHT_RED, 2);
        hold(1'b0, LIGHT_RED, LIGHT_RED, 8);
        do_reset();
        preload(7);
        hold(1'b0, LIGHT_RED, LIGHT_YELLOW, 3);
        hold(1'b0, LIGHT_RED, LIGHT_GREEN, 10);
        hold(1'b0, LIGHT_RED, LIGHT_YELLOW, 3);
        hold(1'b0, LIGHT_RED, LIGHT_GREEN, 10);
        hold(1'b0, LIGHT_RED, LIGHT_YELLOW, 2);
        preload(256);
        hold(1'b0, LIGHT_RED, LIGHT_RED, 4);
        do_reset();
        preload(3);
        hold(1'b1, LIGHT_RED, LIGHT_YELLOW, 3);
        hold(1'b0, LIGHT_RED, LIGHT_YELLOW, 1);
        hold(1'b0, LIGHT_RED, LIGHT_GREEN, 2);
        hold(1'b0, LIGHT_RED, LIGHT_YELLOW, 4);
        do_reset();
        hold(1'b0, LIGHT_GREEN, LIGHT_YELLOW, 2);
        hold(1'b0, LIGHT_GREEN, LIGHT_GREEN, 1);
        hold(1'b0, LIGHT_RED, LIGHT_RED, 2);
        hold(1'b0, LIGHT_RED, LIGHT_GREEN, 2);
        do_reset();
        preload(12);
        hold(1'b1, LIGHT_RED, LIGHT_RED, 3);
        do_reset();
        hold(1'b0, LIGHT_RED, LIGHT_RED, 10);
        slen = 0; llen = 0; s = 0; mr = LIGHT_RED; sr = LIGHT_RED;
        for (int i = 0; i < 4000; i++) begin
            if (--slen <= 0) begin
                s = ~s;
                slen = $urandom_range(1, 6);
            end
            if (--llen <= 0) begin
                sr = 2'($urandom_range(0, 3));
                mr = 2'($urandom_range(0, 3));
                llen = $urandom_range(1, 12);
            end
            if ($urandom_range(0, 999) == 0) do_reset();
            else cyc(s, mr, sr);
        end
        hold(1'b0, LIGHT_RED, LIGHT_RED, 2);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
